pad_ctrl_bank: RTL and testbench

- Parametrised, clocked controller for a bank of NumPads bidirectional pad cells.
- Per channel: selectable mode (off/input/output/bidir) and pull (none/up/down).
- Output-enable turnaround to avoid bus contention; input synchroniser plus debounce filter; edge-detect pulse.
- Sits between SoC pad-mux logic and the technology pad cells (OEN/I/O/PEN/PS pins).

---
 rtl/pad_ctrl_pkg.sv | 29 ++
 rtl/pad_ctrl_channel.sv | 141 ++++++++++++++
 rtl/pad_ctrl_bank.sv | 51 +++++
 tb/tb_pad_ctrl_bank.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
// Shared types and default sizing for the pad control bank.
package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_IN    = 2'b01,
    MODE_OUT   = 2'b10,
    MODE_BIDIR = 2'b11
  } mode_e;

  // Encoding 2'b11 is reserved and treated like PULL_NONE.
  typedef enum logic [1:0] {
    PULL_NONE = 2'b00,
    PULL_DOWN = 2'b01,
    PULL_UP   = 2'b10
  } pull_e;

  typedef enum logic [1:0] {
    ST_HIZ   = 2'b00,
    ST_TURN  = 2'b01,
    ST_DRIVE = 2'b10
  } state_e;

  localparam int NUM_PADS_DEF    = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DBNC_W_DEF      = 8;
  localparam int TURN_CYC_DEF    = 2;

endpackage

// File: rtl/pad_ctrl_channel.sv
// One pad channel: drive FSM with output-enable turnaround, pull control,
// input synchroniser, debounce filter and edge pulse.
module pad_ctrl_channel
  import pad_ctrl_pkg::*;
#(
  parameter int SyncStages       = SYNC_STAGES_DEF,
  parameter int DebounceW        = DBNC_W_DEF,
  parameter int TurnaroundCycles = TURN_CYC_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  mode_e                mode_i,
  input  pull_e                pull_i,
  input  logic [DebounceW-1:0] dbnc_lim_i,
  input  logic                 out_i,
  input  logic                 oe_i,
  input  logic                 pad_o_i,
  output logic                 in_o,
  output logic                 edge_o,
  output logic                 busy_o,
  output logic                 pad_oen_o,
  output logic                 pad_i_o,
  output logic                 pad_pen_o,
  output logic                 pad_ps_o
);

  localparam int TcW = (TurnaroundCycles > 1) ? $clog2(TurnaroundCycles) : 1;
  localparam logic [TcW-1:0] TcLoad =
    TcW'((TurnaroundCycles > 0) ? TurnaroundCycles - 1 : 0);

  state_e                state_q, state_d;
  logic [TcW-1:0]        tcnt_q, tcnt_d;
  logic [SyncStages-1:0] sync_q, sync_d;
  logic [DebounceW-1:0]  dcnt_q, dcnt_d;
  logic                  in_q, in_d;
  logic                  edge_q, edge_d;
  logic                  busy_q, busy_d;
  logic                  oen_q, oen_d;
  logic                  pi_q, pi_d;
  logic                  pen_q, pen_d;
  logic                  ps_q, ps_d;
  logic                  req, pull_on, sync;

  always_comb begin
    req     = (mode_i == MODE_OUT) || ((mode_i == MODE_BIDIR) && oe_i);
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_HIZ: begin
        if (req) begin
          if (TurnaroundCycles == 0) begin
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_TURN;
            tcnt_d  = TcLoad;
          end
        end
      end
      ST_TURN: begin
        if (!req) begin
          state_d = ST_HIZ;
          tcnt_d  = '0;
        end else if (tcnt_q == '0) begin
          state_d = ST_DRIVE;
        end else begin
          tcnt_d = tcnt_q - TcW'(1);
        end
      end
      ST_DRIVE: begin
        if (!req) state_d = ST_HIZ;
      end
      default: state_d = ST_HIZ;
    endcase

    // Outputs are registered from the next state so they line up with it.
    pull_on = (pull_i == PULL_UP) || (pull_i == PULL_DOWN);
    oen_d   = (state_d != ST_DRIVE);
    busy_d  = (state_d == ST_TURN);
    pen_d   = !(pull_on && (mode_i != MODE_OFF) && (state_d != ST_DRIVE));
    ps_d    = (pull_i == PULL_UP);
    pi_d    = out_i;
  end

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pad_o_i};
    sync   = sync_q[SyncStages-1];
    in_d   = in_q;
    dcnt_d = dcnt_q;
    edge_d = 1'b0;
    if (mode_i == MODE_OFF) begin
      in_d   = 1'b0;
      dcnt_d = '0;
      edge_d = in_q;
    end else if (sync == in_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == dbnc_lim_i) begin
      in_d   = sync;
      dcnt_d = '0;
      edge_d = 1'b1;
    end else if (dcnt_q != '1) begin
      dcnt_d = dcnt_q + DebounceW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_HIZ;
      tcnt_q  <= '0;
      sync_q  <= '0;
      dcnt_q  <= '0;
      in_q    <= 1'b0;
      edge_q  <= 1'b0;
      busy_q  <= 1'b0;
      oen_q   <= 1'b1;
      pi_q    <= 1'b0;
      pen_q   <= 1'b1;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      sync_q  <= sync_d;
      dcnt_q  <= dcnt_d;
      in_q    <= in_d;
      edge_q  <= edge_d;
      busy_q  <= busy_d;
      oen_q   <= oen_d;
      pi_q    <= pi_d;
      pen_q   <= pen_d;
      ps_q    <= ps_d;
    end
  end

  assign in_o      = in_q;
  assign edge_o    = edge_q;
  assign busy_o    = busy_q;
  assign pad_oen_o = oen_q;
  assign pad_i_o   = pi_q;
  assign pad_pen_o = pen_q;
  assign pad_ps_o  = ps_q;

endmodule

// File: rtl/pad_ctrl_bank.sv
// Bank of independent pad channels; slices the packed per-pad config fields.
module pad_ctrl_bank
  import pad_ctrl_pkg::*;
#(
  parameter int NumPads          = NUM_PADS_DEF,
  parameter int SyncStages       = SYNC_STAGES_DEF,
  parameter int DebounceW        = DBNC_W_DEF,
  parameter int TurnaroundCycles = TURN_CYC_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2*NumPads-1:0]   cfg_mode_i,
  input  logic [2*NumPads-1:0]   cfg_pull_i,
  input  logic [DebounceW-1:0]   cfg_dbnc_lim_i,
  input  logic [NumPads-1:0]     out_i,
  input  logic [NumPads-1:0]     oe_i,
  output logic [NumPads-1:0]     in_o,
  output logic [NumPads-1:0]     edge_o,
  output logic [NumPads-1:0]     busy_o,
  output logic [NumPads-1:0]     pad_oen_o,
  output logic [NumPads-1:0]     pad_i_o,
  output logic [NumPads-1:0]     pad_pen_o,
  output logic [NumPads-1:0]     pad_ps_o,
  input  logic [NumPads-1:0]     pad_o_i
);

  for (genvar g = 0; g < NumPads; g++) begin : g_pad
    pad_ctrl_channel #(
      .SyncStages      (SyncStages),
      .DebounceW       (DebounceW),
      .TurnaroundCycles(TurnaroundCycles)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .mode_i    (mode_e'(cfg_mode_i[2*g +: 2])),
      .pull_i    (pull_e'(cfg_pull_i[2*g +: 2])),
      .dbnc_lim_i(cfg_dbnc_lim_i),
      .out_i     (out_i[g]),
      .oe_i      (oe_i[g]),
      .pad_o_i   (pad_o_i[g]),
      .in_o      (in_o[g]),
      .edge_o    (edge_o[g]),
      .busy_o    (busy_o[g]),
      .pad_oen_o (pad_oen_o[g]),
      .pad_i_o   (pad_i_o[g]),
      .pad_pen_o (pad_pen_o[g]),
      .pad_ps_o  (pad_ps_o[g])
    );
  end

endmodule

// File: tb/tb_pad_ctrl_bank.sv
// Directed bench for pad_ctrl_bank: table vectors plus multi-cycle sequences.
module tb_pad_ctrl_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mode, pull;
  logic [7:0]  lim, out, oe, pad_o;
  logic [7:0]  in_o, edge_o, busy_o, oen_o, pi_o, pen_o, ps_o;

  int n_vec = 0;
  int n_bad = 0;

  pad_ctrl_bank #(
    .NumPads(8), .SyncStages(2), .DebounceW(8), .TurnaroundCycles(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_mode_i(mode), .cfg_pull_i(pull),
    .cfg_dbnc_lim_i(lim), .out_i(out), .oe_i(oe), .in_o(in_o),
    .edge_o(edge_o), .busy_o(busy_o), .pad_oen_o(oen_o), .pad_i_o(pi_o),
    .pad_pen_o(pen_o), .pad_ps_o(ps_o), .pad_o_i(pad_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] mode, pull;
    logic [7:0]  oe, out;
    logic [7:0]  e_oen, e_busy, e_pen, e_ps, e_pi, e_in, e_edge;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    // pad_o stays 0 for the table; lim fixed at 3
    //               rst  mode     pull     oe     out    oen    busy   pen    ps     pi     in     edge
    tbl[0]  = '{1'b0, 16'h0002, 16'h0000, 8'h00, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 16'h0002, 16'h0000, 8'h00, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 16'h0002, 16'h0000, 8'h00, 8'h01, 8'hFE, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 16'h0002, 16'h0000, 8'h00, 8'h00, 8'hFE, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 16'h0001, 16'h0000, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 16'h0002, 16'h0002, 8'h00, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 16'h0002, 16'h0002, 8'h00, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 16'h0002, 16'h0002, 8'h00, 8'h00, 8'hFE, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{1'b0, 16'h0001, 16'h0003, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 16'h0001, 16'h0001, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 16'hFFFF, 16'hAAAA, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000, 8'h00, 8'h5A, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h5A, 8'h00, 8'h00};

    // Reset with random inputs on every pin.
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      mode = 16'($urandom); pull = 16'($urandom); lim = 8'($urandom);
      out = 8'($urandom); oe = 8'($urandom); pad_o = 8'($urandom);
      tick();
      chk($sformatf("rst%0d oen", i),  oen_o,  8'hFF);
      chk($sformatf("rst%0d pen", i),  pen_o,  8'hFF);
      chk($sformatf("rst%0d in", i),   in_o,   8'h00);
      chk($sformatf("rst%0d edge", i), edge_o, 8'h00);
      chk($sformatf("rst%0d busy", i), busy_o, 8'h00);
      chk($sformatf("rst%0d ps", i),   ps_o,   8'h00);
      chk($sformatf("rst%0d pi", i),   pi_o,   8'h00);
    end
    rst = 1'b0; mode = '0; pull = '0; lim = 8'd3; out = '0; oe = '0; pad_o = '0;
    tick(); tick();

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; mode = tbl[i].mode; pull = tbl[i].pull;
      oe = tbl[i].oe; out = tbl[i].out;
      tick();
      chk($sformatf("vec%0d oen", i),  oen_o,  tbl[i].e_oen);
      chk($sformatf("vec%0d busy", i), busy_o, tbl[i].e_busy);
      chk($sformatf("vec%0d pen", i),  pen_o,  tbl[i].e_pen);
      chk($sformatf("vec%0d ps", i),   ps_o,   tbl[i].e_ps);
      chk($sformatf("vec%0d pi", i),   pi_o,   tbl[i].e_pi);
      chk($sformatf("vec%0d in", i),   in_o,   tbl[i].e_in);
      chk($sformatf("vec%0d edge", i), edge_o, tbl[i].e_edge);
    end
    rst = 1'b0; mode = '0; pull = '0; oe = '0; out = '0;

    // Debounce on pad1 (IN), lim=3: a 3-cycle glitch is rejected.
    begin
      logic seen;
      int   nedge;
      mode = 16'h0004; lim = 8'd3;
      tick(); tick(); tick();
      seen = 1'b0;
      pad_o[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); seen |= in_o[1] | edge_o[1]; end
      pad_o[1] = 1'b0;
      for (int k = 0; k < 10; k++) begin tick(); seen |= in_o[1] | edge_o[1]; end
      chk("glitch_reject", {7'd0, seen}, 8'h00);

      nedge = 0;
      pad_o[1] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        tick();
        nedge += int'(edge_o[1]);
        if (k == 5) chk("dbnc_k5_in", {7'd0, in_o[1]}, 8'h00);
        if (k == 6) begin
          chk("dbnc_k6_in", {7'd0, in_o[1]}, 8'h01);
          chk("dbnc_k6_edge", {7'd0, edge_o[1]}, 8'h01);
        end
      end
      chk("dbnc_edge_count", 8'(nedge), 8'd1);

      // OFF with in_o high: forced low with one edge pulse.
      mode = 16'h0000;
      tick();
      chk("off_in", {7'd0, in_o[1]}, 8'h00);
      chk("off_edge", {7'd0, edge_o[1]}, 8'h01);
      tick();
      chk("off_edge_clr", {7'd0, edge_o[1]}, 8'h00);

      // lim=0: pad to in_o in SyncStages+1 edges.
      pad_o[1] = 1'b0; lim = 8'd0; mode = 16'h0004;
      tick(); tick(); tick(); tick();
      pad_o[1] = 1'b1;
      tick(); tick();
      chk("lim0_k2_in", {7'd0, in_o[1]}, 8'h00);
      tick();
      chk("lim0_k3_in", {7'd0, in_o[1]}, 8'h01);
      chk("lim0_k3_edge", {7'd0, edge_o[1]}, 8'h01);
    end
    mode = '0; pad_o = '0; lim = 8'd3;
    tick(); tick();

    // Pull on pad2 (BIDIR, UP): disabled only while driving.
    mode = 16'h0030; pull = 16'h0020; oe = '0;
    tick();
    chk("pull_hiz_pen", {7'd0, pen_o[2]}, 8'h00);
    chk("pull_hiz_ps",  {7'd0, ps_o[2]},  8'h01);
    oe[2] = 1'b1;
    tick(); chk("pull_turn1_pen", {7'd0, pen_o[2]}, 8'h00);
    tick(); chk("pull_turn2_pen", {7'd0, pen_o[2]}, 8'h00);
    tick();
    chk("pull_drive_pen", {7'd0, pen_o[2]}, 8'h01);
    chk("pull_drive_oen", {7'd0, oen_o[2]}, 8'h00);
    oe[2] = 1'b0;
    tick();
    chk("pull_rel_pen", {7'd0, pen_o[2]}, 8'h00);
    chk("pull_rel_oen", {7'd0, oen_o[2]}, 8'h01);

    // Abort mid-turnaround, then a fresh full turnaround.
    pull = '0;
    tick();
    oe[2] = 1'b1;
    tick();
    chk("abort_turn_busy", {7'd0, busy_o[2]}, 8'h01);
    chk("abort_turn_oen",  {7'd0, oen_o[2]},  8'h01);
    oe[2] = 1'b0;
    tick();
    chk("abort_hiz_busy", {7'd0, busy_o[2]}, 8'h00);
    chk("abort_hiz_oen",  {7'd0, oen_o[2]},  8'h01);
    oe[2] = 1'b1;
    tick(); chk("retry1_busy", {7'd0, busy_o[2]}, 8'h01); chk("retry1_oen", {7'd0, oen_o[2]}, 8'h01);
    tick(); chk("retry2_busy", {7'd0, busy_o[2]}, 8'h01); chk("retry2_oen", {7'd0, oen_o[2]}, 8'h01);
    tick(); chk("retry3_busy", {7'd0, busy_o[2]}, 8'h00); chk("retry3_oen", {7'd0, oen_o[2]}, 8'h00);

    // Reset while driving; request held, full turnaround required afterward.
    rst = 1'b1;
    tick();
    chk("rstdrv_oen",  {7'd0, oen_o[2]},  8'h01);
    chk("rstdrv_busy", {7'd0, busy_o[2]}, 8'h00);
    rst = 1'b0;
    tick(); chk("rerq1_busy", {7'd0, busy_o[2]}, 8'h01); chk("rerq1_oen", {7'd0, oen_o[2]}, 8'h01);
    tick(); chk("rerq2_busy", {7'd0, busy_o[2]}, 8'h01); chk("rerq2_oen", {7'd0, oen_o[2]}, 8'h01);
    tick(); chk("rerq3_oen", {7'd0, oen_o[2]}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
